// File: rtl/stack_sequencer.sv
// stack_sequencer: sequences 1-3 byte stack pushes/pulls and SP loads for the CPU core.
module stack_sequencer #(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd,
    input  logic [23:0] push_data,
    output logic [23:0] pull_data,
    output logic        done,
    output logic        cmd_err,
    input  logic [7:0]  sp_in,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic        sp_load,
    output logic [7:0]  sp_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata
);
    localparam logic [2:0] IDLE = 3'd0, PUSH = 3'd1, PULL_INC = 3'd2, PULL_RD = 3'd3,
                           LOAD = 3'd4, DONE = 3'd5, ERR = 3'd6;
    logic [2:0]  state_q, state_d;
    logic [23:0] data_q, data_d, pull_q, pull_d;
    logic [1:0]  idx_q, idx_d, last_q, last_d;
    logic        accept, last;
    assign accept = cmd_valid & cmd_ready;
    assign last   = idx_q == last_q;
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pull_d  = pull_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (accept) begin
            // Left-align the push bytes so the next byte to send is always data_q[23:16].
            data_d  = cmd[2:1] == 2'd0 ? {push_data[7:0], 16'h0} :
                      cmd[2:1] == 2'd1 ? {push_data[15:0], 8'h0} : push_data;
            pull_d  = '0;
            idx_d   = '0;
            last_d  = cmd[2:1];
            state_d = cmd == 3'd7 ? ERR : cmd == 3'd6 ? LOAD : cmd[0] ? PULL_INC : PUSH;
        end else begin
            case (state_q)
                PUSH: begin
                    data_d  = data_q << 8;
                    idx_d   = idx_q + 2'd1;
                    state_d = last ? DONE : PUSH;
                end
                PULL_INC: state_d = PULL_RD;
                PULL_RD: begin
                    pull_d[{idx_q, 3'b000} +: 8] = mem_rdata;
                    idx_d   = idx_q + 2'd1;
                    state_d = last ? DONE : PULL_RD;
                end
                LOAD:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            pull_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            pull_q  <= pull_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end
    assign cmd_ready = state_q == IDLE || state_q == DONE;
    assign done      = state_q == DONE;
    assign cmd_err   = state_q == ERR;
    assign mem_we    = state_q == PUSH;
    assign mem_re    = state_q == PULL_RD;
    assign sp_dec    = mem_we;
    assign sp_inc    = state_q == PULL_INC || (mem_re && !last);
    assign sp_load   = state_q == LOAD;
    assign sp_data   = sp_load ? data_q[7:0] : 8'h00;
    assign mem_addr  = (mem_we || mem_re) ? {STACK_PAGE, sp_in} : 16'h0000;
    assign mem_wdata = mem_we ? data_q[23:16] : 8'h00;
    assign pull_data = pull_q;
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: directed vectors against a stack pointer register and stack-page memory model.
module tb_stack_sequencer;
    logic        clk, reset, cmd_valid, cmd_ready, done, cmd_err;
    logic [2:0]  cmd;
    logic [23:0] push_data, pull_data;
    logic [7:0]  sp_in, sp_data, mem_wdata, mem_rdata, sp;
    logic        sp_inc, sp_dec, sp_load, mem_we, mem_re;
    logic [15:0] mem_addr;
    logic [7:0]  mem [256];
    int vectors = 0, miscompares = 0, done_cnt = 0, wr_cnt = 0, inv_err = 0, dc, wc;

    stack_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .push_data(push_data), .pull_data(pull_data), .done(done), .cmd_err(cmd_err),
        .sp_in(sp_in), .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_load(sp_load), .sp_data(sp_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    assign sp_in     = sp;
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (reset) sp <= 8'hFF;
        else if (sp_inc) sp <= sp + 8'd1;
        else if (sp_dec) sp <= sp - 8'd1;
        else if (sp_load) sp <= sp_data;
        if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin
        if (!reset && ($countones({sp_inc, sp_dec, sp_load}) > 1 || (mem_we && mem_re) ||
            ((mem_we || mem_re) && mem_addr[15:8] != 8'h01) ||
            (!(mem_we || mem_re) && (mem_addr != 16'h0 || mem_wdata != 8'h0))))
            inv_err <= inv_err + 1;
    end

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [23:0] d);
        chk("ready_before_issue", cmd_ready, 1);
        cmd = c;
        push_data = d;
        cmd_valid = 1;
        tick();
        cmd_valid = 0;
    endtask

    initial begin
        logic [7:0] b3 [3];
        logic [7:0] a3 [3];
        reset = 1; cmd_valid = 0; cmd = 0; push_data = 0;
        tick(); tick();
        chk("reset_outs", {done, cmd_err, sp_inc, sp_dec, sp_load, mem_we, mem_re}, 0);
        chk("reset_bus", {mem_addr, mem_wdata}, 0);
        reset = 0;
        tick();
        chk("ready_after_reset", cmd_ready, 1);
        chk("reset_pull_data", pull_data, 0);
        // PUSH2 12 34 from SP=FF
        issue(3'd2, 24'h001234);
        chk("p2_w0", {mem_we, sp_dec, mem_addr, mem_wdata}, {2'b11, 16'h01FF, 8'h12});
        chk("p2_busy", cmd_ready, 0);
        tick();
        chk("p2_w1", {mem_we, sp_dec, mem_addr, mem_wdata}, {2'b11, 16'h01FE, 8'h34});
        tick();
        chk("p2_done", {done, cmd_ready, mem_we, sp_dec}, 4'b1100);
        chk("p2_sp", sp, 8'hFD);
        tick();
        chk("p2_done_pulse", done, 0);
        // PULL2 from SP=FD
        issue(3'd3, 24'h0);
        chk("l2_inc", {sp_inc, mem_re, mem_we}, 3'b100);
        tick();
        chk("l2_r0", {mem_re, sp_inc, mem_addr, mem_rdata}, {2'b11, 16'h01FE, 8'h34});
        tick();
        chk("l2_r1", {mem_re, sp_inc, mem_addr, mem_rdata}, {2'b10, 16'h01FF, 8'h12});
        tick();
        chk("l2_done", {done, mem_re}, 2'b10);
        chk("l2_data", pull_data, 24'h001234);
        chk("l2_sp", sp, 8'hFF);
        tick();
        // PUSH3 C0 10 A5 then PULL3
        b3 = '{8'hC0, 8'h10, 8'hA5};
        a3 = '{8'hFF, 8'hFE, 8'hFD};
        issue(3'd4, 24'hC010A5);
        for (int i = 0; i < 3; i++) begin
            chk("p3_w", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h01, a3[i], b3[i]});
            tick();
        end
        chk("p3_done", done, 1);
        chk("p3_sp", sp, 8'hFC);
        tick();
        issue(3'd5, 24'hFFFFFF);
        chk("l3_clear", pull_data, 0);
        chk("l3_inc", sp_inc, 1);
        tick();
        for (int i = 2; i >= 0; i--) begin
            chk("l3_r", {mem_re, sp_inc, mem_addr, mem_rdata}, {1'b1, i != 0, 8'h01, a3[i], b3[i]});
            tick();
        end
        chk("l3_done", done, 1);
        chk("l3_data", pull_data, 24'hC010A5);
        chk("l3_sp", sp, 8'hFF);
        tick();
        // LOAD 00, then back-to-back PUSH1 5A accepted in DONE
        issue(3'd6, 24'hABCD00);
        chk("ld", {sp_load, sp_inc, sp_dec, sp_data}, {3'b100, 8'h00});
        tick();
        chk("ld_done", {done, cmd_ready}, 2'b11);
        chk("ld_sp", sp, 8'h00);
        issue(3'd0, 24'h00005A);
        chk("b2b_w", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0100, 8'h5A});
        tick();
        chk("p1_done", done, 1);
        chk("p1_wrap_sp", sp, 8'hFF);
        tick();
        issue(3'd1, 24'h0);
        chk("l1_inc", sp_inc, 1);
        tick();
        chk("l1_r", {mem_re, sp_inc, mem_addr, mem_rdata}, {2'b10, 16'h0100, 8'h5A});
        tick();
        chk("l1_done", {done, pull_data}, {1'b1, 24'h00005A});
        chk("l1_sp", sp, 8'h00);
        tick();
        // reserved command
        dc = done_cnt;
        issue(3'd7, 24'hFFFFFF);
        chk("rsv_err", cmd_err, 1);
        chk("rsv_quiet", {sp_inc, sp_dec, sp_load, mem_we, mem_re, done}, 0);
        tick();
        chk("rsv_err_pulse", {cmd_err, done, cmd_ready}, 3'b001);
        tick();
        chk("rsv_no_done", done_cnt, dc);
        // reset in the middle of PUSH3
        wc = wr_cnt;
        issue(3'd4, 24'h112233);
        chk("rst_w0", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0100, 8'h11});
        reset = 1;
        tick();
        chk("rst_outs", {done, cmd_err, sp_inc, sp_dec, sp_load, mem_we, mem_re}, 0);
        chk("rst_bus", {mem_addr, mem_wdata, sp_data}, 0);
        chk("rst_pull", pull_data, 0);
        chk("rst_one_write", wr_cnt - wc, 1);
        reset = 0;
        tick();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_no_done", done_cnt, dc);
        chk("rst_mem00", mem[8'h00], 8'h11);
        chk("rst_memFF", mem[8'hFF], 8'hC0);
        tick();
        chk("invariants", inv_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Sequences multi-byte stack transactions for the CPU core:
  - PHA/PHP: 1-byte push.
  - PLA/PLP: 1-byte pull.
  - JSR: 2-byte push. RTS: 2-byte pull.
  - BRK/IRQ/NMI: 3-byte push. RTI: 3-byte pull.
  - TXS: load.
- Sits between the control unit and the 8-bit stack pointer register.
- Drives the pointer's inc/dec/load strobes and issues stack-page memory accesses.
- The control unit issues one command and waits for done.

Parameters:
- STACK_PAGE, 8'h01, high address byte of every stack access.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer idle, can accept a command
- cmd  in  3  0 PUSH1, 1 PULL1, 2 PUSH2, 3 PULL2, 4 PUSH3, 5 PULL3, 6 LOAD, 7 reserved
- push_data  in  24  bytes to push / LOAD value in [7:0]; sampled at accept
- pull_data  out  24  bytes pulled; valid when done=1
- done  out  1  one-cycle pulse, command complete
- cmd_err  out  1  one-cycle pulse, reserved command rejected
- sp_in  in  8  current stack pointer value
- sp_inc  out  1  stack pointer increment strobe
- sp_dec  out  1  stack pointer decrement strobe
- sp_load  out  1  stack pointer load strobe
- sp_data  out  8  stack pointer load value
- mem_addr  out  16  memory address
- mem_wdata  out  8  write data
- mem_we  out  1  write enable
- mem_re  out  1  read enable
- mem_rdata  in  8  read data, combinational; valid in the same cycle as mem_addr/mem_re

Behaviour:
- Reset (sync, active-high, any state):
  - State goes to IDLE.
  - cmd_ready=1 the cycle after reset deasserts.
  - done, cmd_err, sp_inc, sp_dec, sp_load, mem_we and mem_re all 0.
  - mem_addr, mem_wdata, sp_data and pull_data are 0.
  - Reset mid-operation abandons the command. Bytes already written and SP steps already taken are not undone, and no done pulse is issued.
- Accept: cmd_valid & cmd_ready at a rising edge (cycle t0).
  - push_data and cmd are latched.
  - pull_data is cleared to 0.
  - cmd_ready=0 from t0+1 until the command completes.
- States: IDLE, PUSH, PULL_INC, PULL_RD, LOAD, DONE.
- PUSHn (n=1,2,3):
  - Bytes go out MSB first: PUSH3 sends [23:16], [15:8], [7:0]; PUSH2 sends [15:8], [7:0]; PUSH1 sends [7:0].
  - Each byte takes one PUSH cycle: mem_addr={STACK_PAGE,sp_in}, mem_wdata=byte, mem_we=1, sp_dec=1.
  - Write cycles are t0+1..t0+n; DONE is at t0+n+1.
- PULLn:
  - t0+1 is PULL_INC: sp_inc=1, no memory access.
  - Each following PULL_RD cycle: mem_addr={STACK_PAGE,sp_in}, mem_re=1, and mem_rdata is captured at the cycle's end.
  - sp_inc=1 in every PULL_RD cycle except the last.
  - Capture order: first byte to [7:0], second to [15:8], third to [23:16]. Unused bytes stay 0.
  - Read cycles are t0+2..t0+n+1; DONE is at t0+n+2.
- LOAD:
  - t0+1: sp_load=1, sp_data=push_data[7:0].
  - DONE at t0+2.
- DONE:
  - done=1 for exactly one cycle; pull_data holds its final value.
  - cmd_ready=1 in the same cycle, so a back-to-back command may be accepted here.
  - pull_data holds until the next accept or reset.
- Reserved cmd=7:
  - Accepted, but produces no strobes and no memory access.
  - cmd_err=1 at t0+1, then IDLE; no done pulse.
- Invariants:
  - At most one of sp_inc, sp_dec, sp_load is high in any cycle.
  - mem_we and mem_re are never high together.
  - mem_addr[15:8]=STACK_PAGE whenever mem_we or mem_re is high.
  - Outside those access cycles, mem_addr and mem_wdata are 0.
  - cmd_valid is ignored while cmd_ready=0.
- Wrap-around is native 8-bit and unflagged:
  - A push at sp_in=8'h00 writes 16'h0100, and the pointer wraps to 8'hFF.
  - A pull with sp_in=8'hFF increments to 8'h00 and reads 16'h0100.

Test Plan:
- Reset, then PUSH2 with push_data=24'h00_12_34 and sp_in tracking an FF-reset pointer:
  - Writes 8'h12 @16'h01FF, then 8'h34 @16'h01FE.
  - sp_dec high for 2 cycles; done at t0+3; final SP=8'hFD.
- PULL2 from SP=8'hFD with memory [01FE]=34, [01FF]=12:
  - sp_inc at t0+1 and t0+2; reads at t0+2 and t0+3.
  - pull_data=24'h00_12_34; done at t0+4; SP=8'hFF.
- PUSH3 with push_data=24'hC0_10_A5, then PULL3:
  - Pulled bytes arrive in order A5, 10, C0; pull_data=24'hC0_10_A5; SP returns to its start value.
- LOAD with push_data[7:0]=8'h00, then PUSH1 8'h5A:
  - sp_load with sp_data=00, then a write @16'h0100.
  - SP wraps to 8'hFF; a following PULL1 reads 16'h0100 and returns 8'h5A.
- Back-to-back: a new cmd_valid held during DONE is accepted in that cycle. Separately, cmd=7 gives a single cmd_err pulse, no strobes and no done.
- Reset asserted at t0+2 of a PUSH3:
  - Exactly one write occurred; all outputs are 0 next cycle; no done pulse.
  - cmd_ready=1 after reset deasserts.
